// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : iq_pkg
//  Description : Types and constants shared by the instruction-queue issue
//                logic (issue FSM states, bundle width, take-count helper).
//  Revision    : 1.0 - initial release
// ============================================================================
package iq_pkg;

  // Number of queue entries that can be captured into one issue bundle
  localparam int IQ_ISSUE_WIDTH = 2;

  // Issue controller states: no bundle, bundle held, one-cycle flush bubble
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FLUSH = 2'd2
  } issue_state_e;

  // Number of entries consumed in a cycle, used to advance the sequence tag
  function automatic logic [1:0] iq_take_count(input logic [IQ_ISSUE_WIDTH-1:0] take);
    return {1'b0, take[0]} + {1'b0, take[1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/iq_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : iq_issue_ctrl
//  Description : Consumer end of the dual-slot instruction queue. Captures up
//                to two in-order head entries per cycle into a registered
//                issue bundle, returns pop strobes to the queue, tags each
//                entry with a wrapping sequence id, and handles the decode
//                valid/ready handshake, flush and single-issue throttle.
//                Optional build macro IQ_ISSUE_PERF_CNT_EN adds saturating
//                stall_cnt / starve_cnt performance counter ports.
//  Revision    : 1.0 - initial release
// ============================================================================
module iq_issue_ctrl
  import iq_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 6
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 flush,
  input  logic                                 single_issue,
  input  logic [IQ_ISSUE_WIDTH-1:0]            head_valid,
  input  logic [IQ_ISSUE_WIDTH*DATA_WIDTH-1:0] head_data,
  output logic [IQ_ISSUE_WIDTH-1:0]            pop,
  output logic [IQ_ISSUE_WIDTH-1:0]            out_valid,
  output logic [IQ_ISSUE_WIDTH*DATA_WIDTH-1:0] out_data,
  input  logic                                 out_ready,
`ifdef IQ_ISSUE_PERF_CNT_EN
  output logic [31:0]                          stall_cnt,
  output logic [31:0]                          starve_cnt,
`endif
  output logic [IQ_ISSUE_WIDTH*ID_WIDTH-1:0]   out_seq
);

  // One bundle slot as held for decode
  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_WIDTH-1:0]   seq;
  } issue_slot_t;

  issue_state_e              r_state;
  issue_state_e              w_state_nxt;
  logic [ID_WIDTH-1:0]       r_seq;
  issue_slot_t               r_slot [IQ_ISSUE_WIDTH];
  logic                      w_load;
  logic [IQ_ISSUE_WIDTH-1:0] w_take;

  // A new bundle may be captured when nothing is held or decode drains the
  // held one; flush and the flush bubble block capture. Reset is folded in so
  // the queue never sees a pop before the state register is initialised.
  always_comb begin
    w_load    = !reset && !flush && (r_state != FLUSH) &&
                ((r_state == EMPTY) || out_ready);
    // Slot 1 is only taken behind slot 0, which also ignores a hole at head
    w_take[0] = w_load & head_valid[0];
    w_take[1] = w_take[0] & head_valid[1] & !single_issue;
    pop       = w_take;
  end

  // Next-state selection: flush wins, bubble drains to EMPTY, load decides
  // between HOLD and EMPTY, otherwise the held bundle stays put
  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = FLUSH;
    end else begin
      case (r_state)
        FLUSH:   w_state_nxt = EMPTY;
        EMPTY,
        HOLD: begin
          if (w_load) begin
            w_state_nxt = w_take[0] ? HOLD : EMPTY;
          end
        end
        default: w_state_nxt = FLUSH;
      endcase
    end
  end

  // State, sequence counter and bundle registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FLUSH;
      r_seq   <= '0;
      for (int i = 0; i < IQ_ISSUE_WIDTH; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      if (flush) begin
        // A bundle handshaked in this cycle is discarded along with the rest
        r_seq <= '0;
        for (int i = 0; i < IQ_ISSUE_WIDTH; i++) begin
          r_slot[i] <= '0;
        end
      end else if (w_load) begin
        r_seq <= r_seq + ID_WIDTH'(iq_take_count(w_take));
        for (int i = 0; i < IQ_ISSUE_WIDTH; i++) begin
          r_slot[i].valid <= w_take[i];
          r_slot[i].data  <= w_take[i] ? head_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
          r_slot[i].seq   <= r_seq + ID_WIDTH'(i);
        end
      end
    end
  end

  // Flatten the bundle slots onto the output buses
  generate
    for (genvar gi = 0; gi < IQ_ISSUE_WIDTH; gi++) begin : g_out
      assign out_valid[gi]                           = r_slot[gi].valid;
      assign out_data[gi*DATA_WIDTH +: DATA_WIDTH]   = r_slot[gi].data;
      assign out_seq[gi*ID_WIDTH +: ID_WIDTH]        = r_slot[gi].seq;
    end
  endgenerate

`ifdef IQ_ISSUE_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_starve_cnt;

  // Saturating stall/starve counters; only reset clears them, flush does not
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt  <= '0;
      r_starve_cnt <= '0;
    end else begin
      if ((r_state == HOLD) && !out_ready && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if ((r_state == EMPTY) && !head_valid[0] && !flush && (r_starve_cnt != '1)) begin
        r_starve_cnt <= r_starve_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign starve_cnt = r_starve_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_iq_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_iq_issue_ctrl
//  Description : Directed self-checking bench for iq_issue_ctrl. Inputs are
//                driven on the falling edge; pop and the registered bundle are
//                sampled 1 time unit later, away from the rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_issue_ctrl;

  localparam int DW = 32;
  localparam int IW = 6;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          single_issue;
  logic [1:0]    head_valid;
  logic [2*DW-1:0] head_data;
  logic [1:0]    pop;
  logic [1:0]    out_valid;
  logic [2*DW-1:0] out_data;
  logic [2*IW-1:0] out_seq;
  logic          out_ready;
`ifdef IQ_ISSUE_PERF_CNT_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   starve_cnt;
`endif

  int n_checks = 0;
  int n_err    = 0;

  iq_issue_ctrl #(.DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .single_issue (single_issue),
    .head_valid   (head_valid),
    .head_data    (head_data),
    .pop          (pop),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
`ifdef IQ_ISSUE_PERF_CNT_EN
    .stall_cnt    (stall_cnt),
    .starve_cnt   (starve_cnt),
`endif
    .out_seq      (out_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance to the next falling edge; inputs are applied after this
  task automatic step();
    @(negedge clk);
  endtask

  // Settle combinational pop after new inputs
  task automatic settle();
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    single_issue = 1'b0;
    head_valid   = 2'b11;
    head_data    = {32'hBBBB_0001, 32'hAAAA_0000};
    out_ready    = 1'b1;

    // ---------------- reset ----------------
    step(); step(); step();
    settle();
    check("rst_pop", 64'(pop), 64'(2'b00));
    check("rst_valid", 64'(out_valid), 64'(2'b00));
    check("rst_data", out_data, 64'h0);
    check("rst_seq", 64'(out_seq), 64'h0);

    // Cycle 0 after reset is the flush bubble: no pop even with two entries
    step();
    reset = 1'b0;
    settle();
    check("rel_c0_pop", 64'(pop), 64'(2'b00));
    check("rel_c0_valid", 64'(out_valid), 64'(2'b00));

    // Cycle 1: EMPTY, both entries taken
    step();
    settle();
    check("rel_c1_pop", 64'(pop), 64'(2'b11));

    // Cycle 2: bundle visible; hold it with out_ready=0 from now
    step();
    out_ready = 1'b0;
    head_data = {32'hDDDD_0003, 32'hCCCC_0002};
    settle();
    check("rel_c2_valid", 64'(out_valid), 64'(2'b11));
    check("rel_c2_seq", 64'(out_seq), 64'({6'd1, 6'd0}));
    check("rel_c2_data", out_data, {32'hBBBB_0001, 32'hAAAA_0000});
    check("bp_pop0", 64'(pop), 64'(2'b00));

    // ---------------- backpressure: 5 more held cycles ----------------
    for (int i = 0; i < 5; i++) begin
      step();
      settle();
      check("bp_pop", 64'(pop), 64'(2'b00));
      check("bp_data", out_data, {32'hBBBB_0001, 32'hAAAA_0000});
      check("bp_seq", 64'(out_seq), 64'({6'd1, 6'd0}));
      check("bp_valid", 64'(out_valid), 64'(2'b11));
    end
    step();
    out_ready = 1'b1;
    settle();
    check("bp_release_pop", 64'(pop), 64'(2'b11));
    step();
    settle();
    check("bp_new_seq", 64'(out_seq), 64'({6'd3, 6'd2}));
    check("bp_new_data", out_data, {32'hDDDD_0003, 32'hCCCC_0002});

    // ---------------- flush mid-HOLD with out_ready=1 ----------------
    flush = 1'b1;
    settle();
    check("fl_pop_c0", 64'(pop), 64'(2'b00));
    step();
    flush = 1'b0;
    settle();
    check("fl_pop_c1", 64'(pop), 64'(2'b00));
    check("fl_valid_c1", 64'(out_valid), 64'(2'b00));
    step();
    settle();
    check("fl_valid_c2", 64'(out_valid), 64'(2'b00));
    check("fl_pop_c2", 64'(pop), 64'(2'b11));
    step();
    settle();
    check("fl_next_seq", 64'(out_seq), 64'({6'd1, 6'd0}));
    check("fl_next_valid", 64'(out_valid), 64'(2'b11));

    // Back-to-back flush: flush while already in FLUSH stays in FLUSH
    flush = 1'b1;
    step();
    settle();
    check("fl2_pop_a", 64'(pop), 64'(2'b00));
    step();
    flush = 1'b0;
    settle();
    check("fl2_pop_b", 64'(pop), 64'(2'b00));

    // ---------------- single-issue throttle ----------------
    step();
    single_issue = 1'b1;
    head_valid   = 2'b11;
    head_data    = {32'h2222_2222, 32'h1111_1111};
    for (int k = 0; k < 4; k++) begin
      settle();
      check("si_pop", 64'(pop), 64'(2'b01));
      if (k > 0) begin
        check("si_valid", 64'(out_valid), 64'(2'b01));
        check("si_seq0", 64'(out_seq[IW-1:0]), 64'(k - 1));
        check("si_data1", out_data[2*DW-1:DW], 64'h0);
      end
      step();
    end

    // ---------------- hole at head, then odd count ----------------
    single_issue = 1'b0;
    head_valid   = 2'b10;
    settle();
    check("si_seq0_last", 64'(out_seq[IW-1:0]), 64'(3));
    check("hole_pop", 64'(pop), 64'(2'b00));
    step();
    head_valid = 2'b01;
    head_data  = {32'h9999_9999, 32'h5555_5555};
    settle();
    check("hole_empty_valid", 64'(out_valid), 64'(2'b00));
    check("odd_pop", 64'(pop), 64'(2'b01));
    step();
    settle();
    check("odd_valid", 64'(out_valid), 64'(2'b01));
    check("odd_seq", 64'(out_seq), 64'({6'd5, 6'd4}));
    check("odd_data", out_data, {32'h0, 32'h5555_5555});

    // ---------------- sequence wrap ----------------
    flush      = 1'b1;
    head_valid = 2'b11;
    step();
    flush = 1'b0;
    step();
    for (int b = 0; b < 31; b++) begin
      settle();
      check("wrap_dual_pop", 64'(pop), 64'(2'b11));
      step();
    end
    single_issue = 1'b1;
    settle();
    check("wrap_last_dual_seq", 64'(out_seq), 64'({6'd61, 6'd60}));
    check("wrap_single_pop", 64'(pop), 64'(2'b01));
    step();
    single_issue = 1'b0;
    settle();
    check("wrap_single_seq0", 64'(out_seq[IW-1:0]), 64'(62));
    step();
    settle();
    check("wrap_seq", 64'(out_seq), 64'({6'd0, 6'd63}));
    check("wrap_valid", 64'(out_valid), 64'(2'b11));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
